// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetch-side {pc, insn} into fields and immediate and
// holds them in a two-entry skid buffer behind a valid/ready handshake.
module decode_stage #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              insn_valid_i,
    output logic              insn_ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              flush_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [2:0]        funct3_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [6:0]        funct7_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              illegal_o
);

    generate
        if (DWIDTH != 32) begin : g_bad_width
            $error("decode_stage supports DWIDTH = 32 only");
        end
    endgenerate

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [6:0]        funct7;
        logic [DWIDTH-1:0] imm;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_reg;
    entry_t out_reg;
    entry_t skid_reg;
    entry_t dec_next;
    logic   in_fire;
    logic   out_fire;

    assign insn_ready_o = (state_reg != FULL);
    assign out_valid_o  = (state_reg != EMPTY);
    assign in_fire      = insn_valid_i & insn_ready_o & ~flush_i;
    assign out_fire     = out_valid_o & out_ready_i;

    // Decode happens before buffering so outputs are pure register reads.
    always_comb begin
        dec_next         = '0;
        dec_next.pc      = pc_i;
        dec_next.insn    = insn_i;
        dec_next.opcode  = insn_i[6:0];
        dec_next.rd      = insn_i[11:7];
        dec_next.funct3  = insn_i[14:12];
        dec_next.rs1     = insn_i[19:15];
        dec_next.rs2     = insn_i[24:20];
        dec_next.funct7  = insn_i[31:25];
        if (insn_i[1:0] != 2'b11) begin
            dec_next.illegal = 1'b1;
        end else begin
            case (insn_i[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                    dec_next.imm = {{20{insn_i[31]}}, insn_i[31:20]};
                7'b0100011:
                    dec_next.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
                7'b1100011:
                    dec_next.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                                    insn_i[30:25], insn_i[11:8], 1'b0};
                7'b0110111, 7'b0010111:
                    dec_next.imm = {insn_i[31:12], 12'b0};
                7'b1101111:
                    dec_next.imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                                    insn_i[20], insn_i[30:21], 1'b0};
                7'b0110011, 7'b0001111:
                    dec_next.imm = '0;
                default:
                    dec_next.illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
        end else if (flush_i) begin
            state_reg <= EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        out_reg   <= dec_next;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_reg <= dec_next;
                    end else if (in_fire) begin
                        skid_reg  <= dec_next;
                        state_reg <= FULL;
                    end else if (out_fire) begin
                        state_reg <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_reg   <= skid_reg;
                        state_reg <= ONE;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

    assign pc_o      = out_reg.pc;
    assign insn_o    = out_reg.insn;
    assign opcode_o  = out_reg.opcode;
    assign rd_o      = out_reg.rd;
    assign funct3_o  = out_reg.funct3;
    assign rs1_o     = out_reg.rs1;
    assign rs2_o     = out_reg.rs2;
    assign funct7_o  = out_reg.funct7;
    assign imm_o     = out_reg.imm;
    assign illegal_o = out_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed and random traffic compared against a queue model
// with an arithmetic reference decoder.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        insn_valid_i;
    logic        insn_ready_o;
    logic [31:0] pc_i;
    logic [31:0] insn_i;
    logic        flush_i;
    logic        out_ready_i;
    logic        out_valid_o;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [6:0]  funct7_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    decode_stage #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .insn_valid_i(insn_valid_i), .insn_ready_o(insn_ready_o),
        .pc_i(pc_i), .insn_i(insn_i), .flush_i(flush_i),
        .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
        .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
        .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct7_o(funct7_o),
        .imm_o(imm_o), .illegal_o(illegal_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    delivered = 0;
    logic  last_in_fire;
    logic  saw_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [31:0] w);
        int op;
        op = int'(w & 32'h7F);
        if ((w & 32'h3) != 32'h3) return 1'b0;
        return op inside {'h13, 'h03, 'h67, 'h73, 'h23, 'h63, 'h37, 'h17, 'h6F, 'h33, 'h0F};
    endfunction

    // Immediate rebuilt by arithmetic shifts/masks of the signed word.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int s;
        int op;
        s  = int'(w);
        op = int'(w & 32'h7F);
        if (!ref_legal(w)) return 32'h0;
        case (op)
            'h13, 'h03, 'h67, 'h73: return 32'(s >>> 20);
            'h23: return 32'(((s >>> 25) << 5) | int'((w >> 7) & 31));
            'h63: return 32'(((s >>> 31) << 12) | int'(((w >> 7) & 1) << 11)
                             | int'(((w >> 25) & 63) << 5) | int'(((w >> 8) & 15) << 1));
            'h37, 'h17: return w & 32'hFFFFF000;
            'h6F: return 32'(((s >>> 31) << 20) | int'(((w >> 12) & 255) << 12)
                             | int'(((w >> 20) & 1) << 11) | int'(((w >> 21) & 1023) << 1));
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid_o), 32'(q.size() > 0));
        chk("insn_ready", 32'(insn_ready_o), 32'(q.size() < 2));
        if (insn_ready_o === 1'b0) saw_full = 1'b1;
        if (q.size() > 0) begin
            chk("pc", pc_o, q[0].pc);
            chk("insn", insn_o, q[0].insn);
            chk("opcode", 32'(opcode_o), q[0].insn % 128);
            chk("rd", 32'(rd_o), (q[0].insn / 128) % 32);
            chk("funct3", 32'(funct3_o), (q[0].insn / 4096) % 8);
            chk("rs1", 32'(rs1_o), (q[0].insn / 32768) % 32);
            chk("rs2", 32'(rs2_o), (q[0].insn / 1048576) % 32);
            chk("funct7", 32'(funct7_o), q[0].insn / 33554432);
            chk("imm", imm_o, ref_imm(q[0].insn));
            chk("illegal", 32'(illegal_o), 32'(!ref_legal(q[0].insn)));
        end
    endtask

    // One clock: drive at negedge, update the model at posedge, check at next negedge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] w,
                         input logic fl, input logic rdy, input logic r);
        bit inf, outf;
        item_t it;
        rst = r; insn_valid_i = v; pc_i = pc; insn_i = w; flush_i = fl; out_ready_i = rdy;
        inf  = v && (q.size() < 2) && !fl && !r;
        outf = (q.size() > 0) && rdy;
        last_in_fire = inf;
        @(posedge clk);
        if (r || fl) begin
            q.delete();
        end else begin
            if (outf) begin
                void'(q.pop_front());
                delivered++;
            end
            if (inf) begin
                it.pc = pc; it.insn = w;
                q.push_back(it);
            end
        end
        @(negedge clk);
        $display("cyc v=%0b pc=%h insn=%h fl=%0b rdy=%0b rst=%0b -> ov=%0b ir=%0b pc_o=%h imm=%h ill=%0b",
                 v, pc, w, fl, rdy, r, out_valid_o, insn_ready_o, pc_o, imm_o, illegal_o);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
        return w;
    endfunction

    task automatic check_zero_data(input string tag);
        chk({tag, "_pc"}, pc_o, 32'h0);
        chk({tag, "_insn"}, insn_o, 32'h0);
        chk({tag, "_imm"}, imm_o, 32'h0);
        chk({tag, "_fields"}, {opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o}, 32'h0);
        chk({tag, "_illegal"}, 32'(illegal_o), 32'h0);
    endtask

    logic [31:0] stream [6] = '{32'h00500093, 32'hFE000EE3, 32'h123450B7,
                                32'h00112623, 32'h0000006F, 32'h40208033};

    initial begin
        int idx;
        rst = 1'b1; insn_valid_i = 0; pc_i = 0; insn_i = 0; flush_i = 0; out_ready_i = 0;
        saw_full = 1'b0;
        @(negedge clk);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check_zero_data("reset");

        // ADDI x1, x0, 5
        cycle(1, 32'h01000000, 32'h00500093, 0, 1, 0);
        chk("addi_valid", 32'(out_valid_o), 32'h1);
        chk("addi_opcode", 32'(opcode_o), 32'h13);
        chk("addi_rd", 32'(rd_o), 32'h1);
        chk("addi_rs1", 32'(rs1_o), 32'h0);
        chk("addi_imm", imm_o, 32'h5);
        cycle(1, 32'h01000004, 32'hFE000EE3, 0, 1, 0);
        chk("beq_imm", imm_o, 32'hFFFFFFFC);
        cycle(1, 32'h01000008, 32'h123450B7, 0, 1, 0);
        chk("lui_imm", imm_o, 32'h12345000);
        chk("lui_rd", 32'(rd_o), 32'h1);
        cycle(1, 32'h0100000C, 32'h00112623, 0, 1, 0);
        chk("sw_imm", imm_o, 32'd12);
        cycle(0, 0, 0, 0, 1, 0);

        // Six-instruction stream with a three-cycle downstream stall
        idx = 0; saw_full = 1'b0; delivered = 0;
        for (int c = 0; c < 40 && (idx < 6 || q.size() > 0); c++) begin
            logic [31:0] w;
            w = (idx < 6) ? stream[idx] : 32'h0;
            cycle(idx < 6, 32'h02000000 + 32'(idx * 4), w, 0, !(c >= 1 && c <= 3), 0);
            if (last_in_fire) idx++;
        end
        chk("stream_accepted", 32'(idx), 32'd6);
        chk("stream_delivered", 32'(delivered), 32'd6);
        chk("stream_saw_full", 32'(saw_full), 32'h1);

        // Flush while FULL with a same-cycle input
        cycle(1, 32'h03000000, 32'h00100113, 0, 0, 0);
        cycle(1, 32'h03000004, 32'h00200193, 0, 0, 0);
        chk("pre_flush_full", 32'(insn_ready_o), 32'h0);
        cycle(1, 32'h03000008, 32'h00300213, 1, 0, 0);
        chk("flush_valid", 32'(out_valid_o), 32'h0);
        chk("flush_ready", 32'(insn_ready_o), 32'h1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("flushed_absent", 32'(out_valid_o), 32'h0);

        // All-zero word is illegal but passes; following legal word clears illegal
        cycle(1, 32'h04000000, 32'h00000000, 0, 1, 0);
        chk("zero_illegal", 32'(illegal_o), 32'h1);
        chk("zero_imm", imm_o, 32'h0);
        chk("zero_valid", 32'(out_valid_o), 32'h1);
        cycle(1, 32'h04000004, 32'h00500093, 0, 1, 0);
        chk("legal_after_illegal", 32'(illegal_o), 32'h0);

        // Random traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, rand_insn(),
                  $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0, 0);
        end

        // Reset mid-stream, with flush also asserted: reset wins and clears data
        cycle(1, 32'h05000000, 32'h00100093, 0, 0, 0);
        cycle(1, 32'h05000004, 32'h00200093, 0, 0, 0);
        cycle(1, 32'h05000008, 32'h00300093, 1, 0, 1);
        check_zero_data("midreset");
        cycle(0, 0, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
